// File: rtl/timer_pkg.sv
// Shared types and defaults for the timer input-capture front end.
package timer_pkg;

   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      EDGE_OFF  = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_sel_e;

   // One captured event at the default counter width.
   typedef struct packed {
      logic                 rise;   // 1 rising, 0 falling
      logic [CNT_W_DEF-1:0] stamp;
   } cap_entry_t;

   // True when the detected edge type is enabled by the selector.
   function automatic logic edge_enabled(edge_sel_e sel, logic rise, logic fall);
      return (rise && (sel == EDGE_RISE || sel == EDGE_BOTH)) ||
             (fall && (sel == EDGE_FALL || sel == EDGE_BOTH));
   endfunction

endpackage

// File: rtl/timer_input_capture_if.sv
// Read-side bus between the capture block and the timer core.
interface timer_input_capture_if #(
   parameter int CNT_W = timer_pkg::CNT_W_DEF
);
   logic             rd_en_i;
   logic             ovf_clr_i;
   logic [CNT_W-1:0] rd_data_o;
   logic             rd_edge_o;
   logic             empty_o;
   logic             full_o;
   logic             ovf_o;
   logic             cap_irq_o;

   // Timer core side: pops entries and clears the overflow flag.
   modport master (
      output rd_en_i, ovf_clr_i,
      input  rd_data_o, rd_edge_o, empty_o, full_o, ovf_o, cap_irq_o
   );

   // Capture block side.
   modport slave (
      input  rd_en_i, ovf_clr_i,
      output rd_data_o, rd_edge_o, empty_o, full_o, ovf_o, cap_irq_o
   );
endinterface

// File: rtl/capture_fifo.sv
// Generic first-word-fall-through synchronous FIFO. DEPTH must be a power of
// two and at least 2; pointers carry one extra wrap bit so full and empty are
// told apart by the MSB compare.
module capture_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 4
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             empty_o,
   output logic             full_o,
   output logic             drop_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             empty_q, empty_d;
   logic             full_q, full_d;
   logic             pop_ok, push_ok;

   // Accept/drop decisions and next pointer/flag state.
   always_comb begin
      // NOTE: every signal written here gets a default first so no path can
      // leave it unassigned and infer a latch.
      pop_ok   = pop_i && !empty_q;
      push_ok  = push_i && (!full_q || pop_ok);
      drop_o   = push_i && full_q && !pop_ok;
      wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
      rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
      empty_d  = (wr_ptr_d == rd_ptr_d);
      full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                 (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
   end

   // Pointer and flag registers; reset drops any queued entries.
   always_ff @(posedge wb_clk_i) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (wb_rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
      end
   end

   // Storage write.
   always_ff @(posedge wb_clk_i) begin
      // NOTE: the storage array has no reset; the pointers alone decide what
      // is valid, and head_o is masked while empty.
      if (push_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
      end
   end

   assign head_o  = empty_q ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   assign empty_o = empty_q;
   assign full_o  = full_q;

endmodule

// File: rtl/timer_input_capture.sv
// Input-capture front end: pad synchroniser, edge detect, prescaled
// timestamp counter and a capture FIFO popped by the timer core.
module timer_input_capture
   import timer_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  cap_pin_i,
   input  logic [1:0]            edge_sel_i,
   input  logic [7:0]            prescale_i,
   input  logic                  cnt_clr_i,
   output logic [CNT_W-1:0]      cnt_o,
   output logic                  cnt_wrap_o,
   timer_input_capture_if.slave  rd_bus
);

   typedef struct packed {
      logic             rise;
      logic [CNT_W-1:0] stamp;
   } entry_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   pin_s;
   logic                   rise_det, fall_det, cap_push;
   edge_sel_e              sel;

   logic [7:0]             psc_q, psc_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   wrap_q, wrap_d;
   logic                   ovf_q, ovf_d;

   entry_t                 push_entry, head_entry;
   logic                   fifo_empty, fifo_full, fifo_drop;

   // Synchroniser chain plus history flop; history tracks the pin every cycle
   // so changing the edge selector can never fabricate an edge.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], cap_pin_i};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // Edge detection against the history flop, filtered by the selector.
   always_comb begin
      pin_s    = sync_q[SYNC_STAGES-1];
      sel      = edge_sel_e'(edge_sel_i);
      rise_det = pin_s && !hist_q;
      fall_det = !pin_s && hist_q;
      cap_push = edge_enabled(sel, rise_det, fall_det);
      push_entry.rise  = rise_det;
      push_entry.stamp = cnt_q;
   end

   // Prescaler and timestamp counter; clear wins over any increment.
   always_comb begin
      psc_d  = psc_q + 8'd1;
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (cnt_clr_i) begin
         psc_d = 8'd0;
         cnt_d = '0;
      end else if (psc_q == prescale_i) begin
         psc_d  = 8'd0;
         cnt_d  = cnt_q + CNT_W'(1);
         wrap_d = &cnt_q;
      end
   end

   // Counter state and the wrap pulse aligned with cnt_o reading zero.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         psc_q  <= 8'd0;
         cnt_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         psc_q  <= psc_d;
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
      end
   end

   // Sticky overflow: a new drop outranks a same-cycle clear.
   always_comb begin
      ovf_d = ovf_q;
      if (rd_bus.ovf_clr_i) ovf_d = 1'b0;
      if (fifo_drop)        ovf_d = 1'b1;
   end

   // Overflow flag register.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) ovf_q <= 1'b0;
      else          ovf_q <= ovf_d;
   end

   capture_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .wb_clk_i    (wb_clk_i),
      .wb_rst_i    (wb_rst_i),
      .push_i      (cap_push),
      .push_data_i (push_entry),
      .pop_i       (rd_bus.rd_en_i),
      .head_o      (head_entry),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full),
      .drop_o      (fifo_drop)
   );

   assign cnt_o            = cnt_q;
   assign cnt_wrap_o       = wrap_q;
   assign rd_bus.rd_data_o = head_entry.stamp;
   assign rd_bus.rd_edge_o = head_entry.rise;
   assign rd_bus.empty_o   = fifo_empty;
   assign rd_bus.full_o    = fifo_full;
   assign rd_bus.ovf_o     = ovf_q;
   assign rd_bus.cap_irq_o = !fifo_empty;

endmodule
